// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control sequencer: state encoding,
// UART register offsets, the "no RX byte" read value and byte strobes.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_DIV  = 3'd2,
        S_TX   = 3'd3,
        S_RX   = 3'd4
    } state_t;

    localparam logic [7:0]  UART_DIV_OFS  = 8'h04;
    localparam logic [7:0]  UART_DAT_OFS  = 8'h08;
    localparam logic [31:0] UART_RX_EMPTY = 32'hFFFF_FFFF;
    localparam logic [3:0]  WSTRB_WORD    = 4'hF;
    localparam logic [3:0]  WSTRB_BYTE0   = 4'h1;

    // Absolute bus address of a UART register.
    function automatic logic [31:0] uart_addr(input logic [31:0] base, input logic [7:0] ofs);
        return base + {24'h0, ofs};
    endfunction

endpackage

// File: rtl/uart_ctrl_fifo.sv
// Small synchronous FIFO holding TX bytes until the sequencer writes them
// to the UART. head is the oldest entry and is valid whenever !empty.
module uart_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_ctrl_seq.sv
// Bus master that owns the UART slave port: programs the baud divider after
// reset and on request, drains the TX FIFO into the data register, and polls
// the data register for RX bytes presented on a one-entry valid/ready stream.
module uart_ctrl_seq
    import uart_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] INIT_DIV  = 32'd104,
    parameter int          TX_DEPTH  = 8,
    parameter int          POLL_GAP  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_div,
    input  logic        cfg_div_load,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int          PW       = $clog2(POLL_GAP);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_GAP - 1);
    localparam logic [31:0] DIV_ADDR = uart_addr(BASE_ADDR, UART_DIV_OFS);
    localparam logic [31:0] DAT_ADDR = uart_addr(BASE_ADDR, UART_DAT_OFS);

    state_t                   state;
    logic                     last_tx;
    logic [31:0]              div_val;
    logic                     div_pend;
    logic [PW-1:0]            poll_cnt;
    logic                     ready_en;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(TX_DEPTH):0] fifo_count;
    logic [7:0]               fifo_head;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     xfer_done;
    logic                     rx_elig;
    logic                     go_rx;

    assign xfer_done = m_valid && m_ready;
    assign tx_ready  = ready_en && !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign fifo_pop  = (state == S_TX) && xfer_done;
    // A poll is only allowed when the holding register can take the byte.
    assign rx_elig   = (poll_cnt >= POLL_MAX) && !rx_valid;
    // With both sides eligible, alternate so neither starves the other.
    assign go_rx     = rx_elig && (fifo_empty || last_tx);
    assign busy      = (state != S_IDLE) || (fifo_count != '0) || div_pend;

    uart_ctrl_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // tx_ready stays low during reset and rises on the first clock after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // Sequencer FSM with registered bus request; m_valid always drops for
    // at least one IDLE cycle after each completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_INIT;
            last_tx <= 1'b0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_addr  <= DIV_ADDR;
                        m_wdata <= INIT_DIV;
                        m_wstrb <= WSTRB_WORD;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (div_pend) begin
                        m_valid <= 1'b1;
                        m_addr  <= DIV_ADDR;
                        m_wdata <= div_val;
                        m_wstrb <= WSTRB_WORD;
                        state   <= S_DIV;
                    end else if (go_rx) begin
                        m_valid <= 1'b1;
                        m_addr  <= DAT_ADDR;
                        m_wdata <= '0;
                        m_wstrb <= 4'h0;
                        state   <= S_RX;
                    end else if (!fifo_empty) begin
                        m_valid <= 1'b1;
                        m_addr  <= DAT_ADDR;
                        m_wdata <= {24'h0, fifo_head};
                        m_wstrb <= WSTRB_BYTE0;
                        state   <= S_TX;
                    end
                end
                S_DIV, S_TX, S_RX: begin
                    if (xfer_done) begin
                        m_valid <= 1'b0;
                        state   <= S_IDLE;
                        if (state == S_TX) last_tx <= 1'b1;
                        if (state == S_RX) last_tx <= 1'b0;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Divider request: latest pulse wins; a new pulse outranks the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_val  <= '0;
            div_pend <= 1'b0;
        end else if (cfg_div_load) begin
            div_val  <= cfg_div;
            div_pend <= 1'b1;
        end else if ((state == S_DIV) && xfer_done) begin
            div_pend <= 1'b0;
        end
    end

    // Poll spacing counter: frozen during a poll, cleared when it completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
        end else if (state == S_RX) begin
            if (xfer_done) poll_cnt <= '0;
        end else if (poll_cnt != POLL_MAX) begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // One-entry RX holding register; the all-ones read means no byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if ((state == S_RX) && xfer_done && (m_rdata != UART_RX_EMPTY)) begin
            rx_valid <= 1'b1;
            rx_data  <= m_rdata[7:0];
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ctrl_seq.sv
// Self-checking bench for uart_ctrl_seq: a bus slave model with configurable
// stall, a transaction log, a table of TX vectors and directed sequences.
module tb_uart_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_div = '0;
    logic        cfg_div_load = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = '0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    uart_ctrl_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_div      (cfg_div),
        .cfg_div_load (cfg_div_load),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_rdata      (m_rdata),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } txn_t;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } txvec_t;

    txn_t        log_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          ready_tie = 1'b0;
    bit          hold_ready = 1'b0;
    int          ready_delay = 0;

    // Slave state
    int          wcnt = 0;
    bit          done_flag = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] cap_a, cap_d;
    logic [3:0]  cap_s;
    bit          rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit is_rd(input txn_t t);
        return t.s == 4'h0;
    endfunction
    function automatic bit is_div(input txn_t t);
        return (t.s != 4'h0) && (t.a == 32'h4);
    endfunction
    function automatic bit is_tx(input txn_t t);
        return (t.s != 4'h0) && (t.a != 32'h4);
    endfunction
    function automatic int n_rd();
        int n = 0;
        foreach (log_q[i]) if (is_rd(log_q[i])) n++;
        return n;
    endfunction
    function automatic int n_tx();
        int n = 0;
        foreach (log_q[i]) if (is_tx(log_q[i])) n++;
        return n;
    endfunction
    function automatic int n_div();
        int n = 0;
        foreach (log_q[i]) if (is_div(log_q[i])) n++;
        return n;
    endfunction

    // Bus slave: decides m_ready on the falling edge, logs each transaction
    // that will complete on the next rising edge, and checks the protocol.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_ready   = 1'b0;
            wcnt      = 0;
            done_flag = 1'b0;
            seen      = 1'b0;
        end else begin
            if (done_flag) chk("valid_drop_after_completion", {31'h0, m_valid}, 32'h0);
            done_flag = 1'b0;
            if (m_valid) begin
                if (seen) begin
                    chk("stable_addr", m_addr, cap_a);
                    chk("stable_wdata", m_wdata, cap_d);
                    chk("stable_wstrb", {28'h0, m_wstrb}, {28'h0, cap_s});
                end else begin
                    cap_a = m_addr;
                    cap_d = m_wdata;
                    cap_s = m_wstrb;
                    seen  = 1'b1;
                end
                rdy = ready_tie || (!hold_ready && (wcnt >= ready_delay));
                if (rdy) begin
                    m_ready = 1'b1;
                    log_q.push_back('{m_addr, m_wdata, m_wstrb});
                    if (m_wstrb == 4'h0) begin
                        m_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
                        $display("bus rd addr=%08h rdata=%08h", m_addr, m_rdata);
                    end else begin
                        $display("bus wr addr=%08h wdata=%08h wstrb=%h", m_addr, m_wdata, m_wstrb);
                    end
                    done_flag = 1'b1;
                    seen      = 1'b0;
                    wcnt      = 0;
                end else begin
                    m_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                m_ready = ready_tie;
                wcnt    = 0;
                seen    = 1'b0;
            end
        end
    end

    // Main flow runs 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b, input int budget, output bit ok);
        tx_data  = b;
        tx_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            ok = tx_ready;
            step();
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        txvec_t      vec[9];
        txn_t        w[$];
        logic [7:0]  exp2[3];
        bit          ok;
        int          k, nr, first_i, last_i, same, rd_between;

        vec = '{
            '{8'hA0, 32'h08, 32'h0000_00A0, 4'h1},
            '{8'h5A, 32'h08, 32'h0000_005A, 4'h1},
            '{8'h00, 32'h08, 32'h0000_0000, 4'h1},
            '{8'hFF, 32'h08, 32'h0000_00FF, 4'h1},
            '{8'h3C, 32'h08, 32'h0000_003C, 4'h1},
            '{8'hC3, 32'h08, 32'h0000_00C3, 4'h1},
            '{8'h11, 32'h08, 32'h0000_0011, 4'h1},
            '{8'hEE, 32'h08, 32'h0000_00EE, 4'h1},
            '{8'h7E, 32'h08, 32'h0000_007E, 4'h1}
        };
        exp2 = '{8'h41, 8'h42, 8'h43};

        // ---- T1: reset values and INIT divider write ----
        repeat (3) step();
        chk("rst_m_valid", {31'h0, m_valid}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstrb", {28'h0, m_wstrb}, 0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 0);
        chk("rst_rx_data", {24'h0, rx_data}, 0);
        chk("rst_tx_ready", {31'h0, tx_ready}, 0);
        chk("rst_busy", {31'h0, busy}, 1);
        ready_tie = 1'b1;
        reset_n = 1'b1;
        step();
        chk("first_clk_tx_ready", {31'h0, tx_ready}, 1);
        for (k = 0; k < 20 && log_q.size() == 0; k++) step();
        chk("init_seen", {31'h0, log_q.size() != 0}, 1);
        if (log_q.size() != 0) begin
            chk("init_addr", log_q[0].a, 32'h4);
            chk("init_wdata", log_q[0].d, 32'd104);
            chk("init_wstrb", {28'h0, log_q[0].s}, 32'hF);
        end
        step();
        ready_tie = 1'b0;
        ready_delay = 20;

        // ---- T2: three bytes with a stalling slave ----
        step();
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            push(exp2[i], 10, ok);
            chk("t2_push", {31'h0, ok}, 1);
        end
        for (k = 0; k < 1000 && n_tx() < 3; k++) step();
        chk("t2_count", n_tx(), 3);
        w.delete();
        foreach (log_q[i]) if (is_tx(log_q[i])) w.push_back(log_q[i]);
        for (int i = 0; i < 3 && i < w.size(); i++) begin
            chk("t2_addr", w[i].a, 32'h8);
            chk("t2_wdata", w[i].d, {24'h0, exp2[i]});
            chk("t2_wstrb", {28'h0, w[i].s}, 32'h1);
        end
        step();

        // ---- T3: table-driven fill past depth ----
        log_q.delete();
        hold_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(vec[i].data, 4, ok);
            chk("t3_push_ok", {31'h0, ok}, 1);
        end
        chk("t3_full_tx_ready", {31'h0, tx_ready}, 0);
        tx_data  = vec[8].data;
        tx_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_ready) k++;
            step();
        end
        chk("t3_blocked", k, 0);
        hold_ready  = 1'b0;
        ready_delay = 3;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = tx_ready;
            step();
        end
        tx_valid = 1'b0;
        chk("t3_ninth_accepted", {31'h0, ok}, 1);
        chk("t3_pop_before_ninth", {31'h0, n_tx() >= 1}, 1);
        for (k = 0; k < 2000 && n_tx() < 9; k++) step();
        chk("t3_count", n_tx(), 9);
        w.delete();
        foreach (log_q[i]) if (is_tx(log_q[i])) w.push_back(log_q[i]);
        for (int i = 0; i < 9 && i < w.size(); i++) begin
            chk("t3_addr", w[i].a, vec[i].exp_addr);
            chk("t3_wdata", w[i].d, vec[i].exp_wdata);
            chk("t3_wstrb", {28'h0, w[i].s}, {28'h0, vec[i].exp_wstrb});
        end
        step();

        // ---- T4: RX empty poll, then byte 0xFF held until consumed ----
        ready_delay = 0;
        log_q.delete();
        rd_q.push_back(32'hFFFF_FFFF);
        rd_q.push_back(32'h0000_00FF);
        for (k = 0; k < 300 && !rx_valid; k++) step();
        chk("t4_rx_valid", {31'h0, rx_valid}, 1);
        chk("t4_rx_data", {24'h0, rx_data}, 32'hFF);
        chk("t4_reads", n_rd(), 2);
        nr = n_rd();
        repeat (60) step();
        chk("t4_no_poll_while_full", n_rd(), nr);
        chk("t4_rx_valid_held", {31'h0, rx_valid}, 1);
        chk("t4_rx_data_held", {24'h0, rx_data}, 32'hFF);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        chk("t4_rx_consumed", {31'h0, rx_valid}, 0);
        repeat (40) step();
        chk("t4_poll_resumes", {31'h0, n_rd() > nr}, 1);

        // ---- T5: TX/RX alternation ----
        ready_delay = 20;
        step();
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(8'hB0 + 8'(i), 10, ok);
            chk("t5_push", {31'h0, ok}, 1);
        end
        for (k = 0; k < 2000 && n_tx() < 4; k++) step();
        chk("t5_count", n_tx(), 4);
        first_i = -1;
        last_i  = -1;
        foreach (log_q[i]) if (is_tx(log_q[i])) begin
            if (first_i < 0) first_i = i;
            last_i = i;
        end
        same = 0;
        rd_between = 0;
        if (first_i >= 0) begin
            for (int i = first_i; i <= last_i; i++) begin
                if (is_rd(log_q[i])) rd_between++;
                if (i < last_i && (is_rd(log_q[i]) == is_rd(log_q[i+1]))) same++;
            end
        end
        chk("t5_reads_between", rd_between, 3);
        chk("t5_adjacent_same", same, 0);
        step();

        // ---- T6: two cfg_div_load pulses during one TX write ----
        log_q.delete();
        push(8'h55, 10, ok);
        push(8'h66, 10, ok);
        for (k = 0; k < 300 && !(m_valid && m_wstrb == 4'h1); k++) step();
        chk("t6_tx_started", {31'h0, m_valid && m_wstrb == 4'h1}, 1);
        cfg_div = 32'h10;
        cfg_div_load = 1'b1;
        step();
        cfg_div_load = 1'b0;
        step();
        cfg_div = 32'h20;
        cfg_div_load = 1'b1;
        step();
        cfg_div_load = 1'b0;
        for (k = 0; k < 1000 && n_tx() < 2; k++) step();
        step();
        w.delete();
        foreach (log_q[i]) if (log_q[i].s != 4'h0) w.push_back(log_q[i]);
        chk("t6_writes", w.size(), 3);
        chk("t6_div_count", n_div(), 1);
        if (w.size() >= 3) begin
            chk("t6_w0_wdata", w[0].d, 32'h55);
            chk("t6_w1_addr", w[1].a, 32'h4);
            chk("t6_w1_wdata", w[1].d, 32'h20);
            chk("t6_w1_wstrb", {28'h0, w[1].s}, 32'hF);
            chk("t6_w2_wdata", w[2].d, 32'h66);
        end
        first_i = -1;
        foreach (log_q[i]) if (first_i < 0 && is_tx(log_q[i])) first_i = i;
        if (first_i >= 0 && first_i + 1 < log_q.size())
            chk("t6_div_next", {31'h0, is_div(log_q[first_i+1])}, 1);
        else
            chk("t6_div_next_present", 32'h0, 32'h1);

        // ---- T7: reset in the middle of a TX write ----
        ready_delay = 50;
        step();
        push(8'h77, 10, ok);
        push(8'h78, 10, ok);
        for (k = 0; k < 400 && !(m_valid && m_wstrb == 4'h1); k++) step();
        chk("t7_tx_started", {31'h0, m_valid && m_wstrb == 4'h1}, 1);
        reset_n = 1'b0;
        #1;
        chk("t7_m_valid_drop", {31'h0, m_valid}, 0);
        chk("t7_busy", {31'h0, busy}, 1);
        chk("t7_tx_ready", {31'h0, tx_ready}, 0);
        repeat (3) step();
        log_q.delete();
        ready_delay = 0;
        reset_n = 1'b1;
        for (k = 0; k < 50 && log_q.size() == 0; k++) step();
        chk("t7_init_seen", {31'h0, log_q.size() != 0}, 1);
        if (log_q.size() != 0) begin
            chk("t7_init_addr", log_q[0].a, 32'h4);
            chk("t7_init_wdata", log_q[0].d, 32'd104);
            chk("t7_init_wstrb", {28'h0, log_q[0].s}, 32'hF);
        end
        repeat (100) step();
        chk("t7_fifo_discarded", n_tx(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
